// File: rtl/clk_div_monitor.sv
// Half-period monitor for a clk-synchronous divided clock: measures, checks, tracks lock, flags stuck.
// Optional SYNC_EN macro inserts a 2-flop synchronizer ahead of edge detection.
module clk_div_monitor #(
  parameter int CNT_W    = 8,
  parameter int EXP_HALF = 4,
  parameter int TOL      = 0,
  parameter int LOCK_N   = 3,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             stuck
);

  // state | meaning
  // WAIT  | no reference edge yet (after reset or timeout); next edge starts measuring
  // MEAS  | every edge closes a half-period that is reported and checked
  typedef enum logic {WAIT, MEAS} state_t;

  localparam int MW = $clog2(LOCK_N + 1);
  localparam logic [MW-1:0]    LOCK_V    = MW'(LOCK_N);
  localparam logic [CNT_W:0]   EXP_V     = (CNT_W+1)'(EXP_HALF);
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [MW-1:0]    match_cnt;
  logic [MW-1:0]    match_inc;
  logic [CNT_W:0]   cnt_x;
  logic [CNT_W:0]   diff;
  logic             match;
  logic             div_s;
  logic             div_q;
  logic             div_edge;

`ifdef SYNC_EN
  logic sync1, sync2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= div_in;
      sync2 <= sync1;
    end
  end

  assign div_s = sync2;
`else
  assign div_s = div_in;
`endif

  assign div_edge  = div_s ^ div_q;
  assign cnt_x     = {1'b0, cnt};
  assign diff      = (cnt_x >= EXP_V) ? (cnt_x - EXP_V) : (EXP_V - cnt_x);
  assign match     = (diff <= TOL_V);
  assign match_inc = (match_cnt == LOCK_V) ? LOCK_V : (match_cnt + 1'b1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= WAIT;
      cnt         <= '0;
      match_cnt   <= '0;
      div_q       <= 1'b0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      stuck       <= 1'b0;
    end else begin
      div_q      <= div_s;
      meas_valid <= 1'b0;
      err        <= 1'b0;

      if (div_edge)
        cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      // An edge always beats a coincident timeout.
      if (div_edge) begin
        stuck <= 1'b0;
        if (state == WAIT) begin
          state <= MEAS;
        end else begin
          half_period <= cnt;
          meas_valid  <= 1'b1;
          if (match) begin
            match_cnt <= match_inc;
            if (match_inc == LOCK_V)
              locked <= 1'b1;
          end else begin
            err       <= 1'b1;
            match_cnt <= '0;
            locked    <= 1'b0;
          end
        end
      end else if (cnt == TIMEOUT_V) begin
        stuck     <= 1'b1;
        locked    <= 1'b0;
        match_cnt <= '0;
        state     <= WAIT;
      end
    end
  end

endmodule
